vram_arbiter: RTL

- Shares one single-port synchronous video RAM between the VGA pixel fetch path and a CPU load/store port.
- Holds two 160x120 8-bit frame pages (double buffering): VGA reads the display page, the CPU accesses the draw page.
- Page swaps are requested by the CPU and applied only at the frame boundary.
- Sits between the VGA signal generator (req/row/column in, pixel data out), the CPU bus and the RAM.

---
 rtl/vram_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between the VGA
// pixel fetch path (fixed-latency reads, always wins) and a CPU load/store
// port (request/ack handshake). Two 160x120 8-bit pages are held in the RAM;
// VGA scans the display page, the CPU works on the other, and page swaps
// requested by the CPU take effect only at the frame boundary.
module vram_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int PAGE_SIZE   = 19200,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [8:0]        vga_row,
    input  logic [9:0]        vga_col,
    output logic [7:0]        vga_data,
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              display_page,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [14:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        C_IDLE,
        C_RD_WAIT,
        C_DONE
    } cpu_state_e;

    cpu_state_e        cpu_state_q, cpu_state_d;
    logic              vga_cap_q, vga_cap_d;
    logic              vga_ok_q, vga_ok_d;
    logic [7:0]        vga_data_q, vga_data_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic              cpu_err_q, cpu_err_d;
    logic              display_page_q, display_page_d;
    logic              swap_pending_q, swap_pending_d;

    logic              vga_in_range;
    logic              cpu_addr_ok;
    logic              cpu_issue;
    logic [ADDR_W-1:0] vga_addr;
    logic [ADDR_W-1:0] cpu_full_addr;

    // Address generation for both channels; the CPU targets the page not on screen.
    always_comb begin
        vga_in_range  = (vga_row < 9'd480) && (vga_col < 10'd640);
        cpu_addr_ok   = ADDR_W'(cpu_addr) < ADDR_W'(PAGE_SIZE);
        vga_addr      = (display_page_q ? ADDR_W'(PAGE_SIZE) : '0)
                      + ADDR_W'(vga_row >> SCALE_SHIFT) * ADDR_W'(FB_W)
                      + ADDR_W'(vga_col >> SCALE_SHIFT);
        cpu_full_addr = (display_page_q ? '0 : ADDR_W'(PAGE_SIZE)) + ADDR_W'(cpu_addr);
    end

    // Issue decision: VGA first, then an idle CPU; out-of-range requests touch no RAM.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = cpu_wdata;
        vga_cap_d = 1'b0;
        vga_ok_d  = 1'b0;
        cpu_issue = 1'b0;
        if (vga_req) begin
            vga_cap_d = 1'b1;
            vga_ok_d  = vga_in_range;
            if (vga_in_range) begin
                mem_addr = vga_addr;
            end
        end else if (cpu_state_q == C_IDLE && cpu_req) begin
            cpu_issue = 1'b1;
            if (cpu_addr_ok) begin
                mem_addr = cpu_full_addr;
                mem_we   = cpu_we & ~reset;
            end
        end
    end

    // VGA capture: one cycle after issue, take RAM data (or zero if the pixel was off-screen).
    always_comb begin
        vga_data_d = vga_data_q;
        if (vga_cap_q) begin
            vga_data_d = vga_ok_q ? mem_rdata : 8'h00;
        end
    end

    // CPU FSM next state: error and write go straight to C_DONE, reads wait one cycle.
    always_comb begin
        cpu_state_d = cpu_state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_err_d   = 1'b0;
        case (cpu_state_q)
            C_IDLE: begin
                if (cpu_issue) begin
                    if (!cpu_addr_ok) begin
                        cpu_state_d = C_DONE;
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = 8'h00;
                    end else if (cpu_we) begin
                        cpu_state_d = C_DONE;
                    end else begin
                        cpu_state_d = C_RD_WAIT;
                    end
                end
            end
            C_RD_WAIT: begin
                cpu_rdata_d = mem_rdata;
                cpu_state_d = C_DONE;
            end
            C_DONE: begin
                cpu_state_d = C_IDLE;
            end
            default: begin
                cpu_state_d = C_IDLE;
            end
        endcase
    end

    // Page swap: remember a request, apply it only on a frame_start cycle.
    always_comb begin
        display_page_d = display_page_q;
        swap_pending_d = swap_pending_q;
        if (frame_start && (swap_pending_q || swap_req)) begin
            display_page_d = ~display_page_q;
            swap_pending_d = 1'b0;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            cpu_state_q    <= C_IDLE;
            vga_cap_q      <= 1'b0;
            vga_ok_q       <= 1'b0;
            vga_data_q     <= 8'h00;
            cpu_rdata_q    <= 8'h00;
            cpu_err_q      <= 1'b0;
            display_page_q <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            cpu_state_q    <= cpu_state_d;
            vga_cap_q      <= vga_cap_d;
            vga_ok_q       <= vga_ok_d;
            vga_data_q     <= vga_data_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_err_q      <= cpu_err_d;
            display_page_q <= display_page_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    assign vga_data     = vga_data_q;
    assign cpu_ack      = (cpu_state_q == C_DONE);
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_err      = cpu_err_q;
    assign display_page = display_page_q;
    assign swap_pending = swap_pending_q;

endmodule
